uart_tx_word_arbiter: RTL and testbench
=======================================

// Module: uart_tx_word_arbiter
// PURPOSE
//  Shares one byte-wide UART transmitter among NUM_REQ bus-side requesters, each offering 32-bit words.
//  Grants one requester at a time (round-robin) and serialises the granted word into 4 bytes, LSB first.
//  Each byte is handed to the UART TX byte engine over a valid/ready handshake.
//  Sits between the bus slave ports and the UART TX. This is the transmit-side counterpart of the byte-to-word RX assembly.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_WIDTH  32  word width; fixed at 4 bytes (DATA_WIDTH/8 = 4)
// PORTS
//  clk        in   1               system clock, all logic on posedge
//  rst        in   1               synchronous, active-high reset
//  req        in   NUM_REQ         per-requester word request; held high until its grant pulse
//  req_data   in   NUM_REQ*32      packed words; requester i owns bits [32*i+31:32*i]
//  grant      out  NUM_REQ         one-hot, 1-cycle pulse: word of that requester latched
//  tx_data    out  8               byte to UART TX
//  tx_valid   out  1               tx_data valid; held until tx_ready
//  tx_ready   in   1               UART TX accepts byte when tx_valid && tx_ready
//  busy       out  1               high from grant cycle until last byte accepted
//  word_done  out  1               1-cycle pulse on acceptance of last byte of a word
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; grant=0, tx_valid=0, tx_data=0, busy=0, word_done=0.
//   Also rr_ptr=0 and byte_cnt=0. Any word in flight is dropped; its requester is already granted and is not re-served.
//  FSM (3 states; 4 with UART_TX_ARB_HDR_EN):
//   IDLE: if |req: winner = first set req at or after rr_ptr, wrapping modulo NUM_REQ.
//    Latch the winner's word into shift_reg; grant[winner]=1 for this cycle; rr_ptr <= winner+1 (wraps to 0).
//    byte_cnt<=0; busy<=1; next = SEND (or HDR). If req==0, stay IDLE.
//   HDR (macro only): tx_valid=1, tx_data={5'b10100, winner[2:0]}; on tx_ready -> SEND.
//   SEND: tx_valid=1, tx_data=shift_reg[7:0]. On tx_valid&&tx_ready: shift_reg>>=8 and byte_cnt++.
//    If byte_cnt==3 at that handshake: word_done=1 next cycle, busy<=0, tx_valid<=0, next=IDLE.
//  tx_valid/tx_data are registered. tx_data must not change while tx_valid=1 && tx_ready=0.
//  Latency, req to first tx_valid: 2 cycles (IDLE sample, then registered output).
//  Minimum per word with tx_ready tied 1: 6 cycles (7 with header).
//  No arbitration during SEND/HDR: new reqs wait; req changes mid-word are ignored.
//  word_done and a new grant never coincide: IDLE is always spent for >=1 cycle after word_done.
//  Requester keeping req high after its grant re-enters arbitration and gets lowest priority next round.
//  tx_ready high while tx_valid=0: ignored. byte_cnt is 2 bits, wraps only via state exit.
//  Requester indices >= NUM_REQ never granted; rr_ptr wraps NUM_REQ-1 -> 0.
// CONFIGURATION
//  UART_TX_ARB_HDR_EN defined: HDR state active. One header byte {5'b10100, id[2:0]} precedes each word (5 bytes/word).
//  Not defined: HDR state and its logic absent; 4 bytes/word, no framing.
// STRUCTURE
//  Package uart_arb_pkg: typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_SEND} arb_state_t.
//   Also BYTES_PER_WORD=4 and HDR_TAG=5'b10100.
//  Sub-module rr_arbiter #(N): inputs req and ptr; outputs one-hot gnt_oh and binary gnt_idx.
//   Purely combinational; instantiated once.
//  Top holds FSM, shift_reg, byte_cnt, rr_ptr and output registers.
// TESTING
//  1 req[0]=1, word 0xDEADBEEF, tx_ready=1 -> grant[0] pulse; bytes EF,BE,AD,DE on consecutive handshakes; word_done once.
//  2 req[1]&req[2] same cycle (rr_ptr=0), data 0x11111111/0x22222222 -> requester 1 fully sent, then requester 2.
//  3 req[3] held high, req[0] asserted mid-word -> after word_done, req[0] wins (rr_ptr=0), then 3.
//  4 tx_ready low 5 cycles on byte 2 of 0xA5A5C3C3 -> tx_valid held, tx_data stays 0xA5 until ready.
//   Then remaining bytes in order; no drop or duplicate.
//  5 rst=1 after 2nd byte accepted -> next cycle tx_valid=0, busy=0, IDLE.
//   Re-request 0x01020304 then sends 04,03,02,01.
//  6 UART_TX_ARB_HDR_EN, req[2] word 0x0000CAFE -> bytes A2,FE,CA,00,00; word_done after 5th.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the word-to-byte UART TX arbiter.
// Header framing is enabled by defining UART_TX_ARB_HDR_EN.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_SEND = 2'd2
   } arb_state_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_W         = 8;
   localparam logic [4:0]  HDR_TAG        = 5'b10100;

   // Framing byte announcing which requester owns the following word
   function automatic logic [7:0] hdr_byte(input logic [2:0] id);
      return {HDR_TAG, id};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx
);

   logic              found;
   int unsigned       cand;
   logic [IW-1:0]     cand_idx;

   always_comb begin
      gnt_oh   = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand     = (32'(ptr) + k) % N;
         cand_idx = IW'(cand);
         if (!found && req[cand_idx]) begin
            found            = 1'b1;
            gnt_oh[cand_idx] = 1'b1;
            gnt_idx          = cand_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter serialising 32-bit requester words into LSB-first bytes for a UART TX.
// Define UART_TX_ARB_HDR_EN to prefix each word with a {10100, id} header byte.
module uart_tx_word_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic                          busy,
   output logic                          word_done
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t              state, state_nxt;
   logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
   logic [1:0]              byte_cnt, cnt_nxt;
   logic [IW-1:0]           rr_ptr, ptr_nxt;
   logic [NUM_REQ-1:0]      grant_nxt;
   logic [7:0]              data_nxt;
   logic                    valid_nxt;
   logic                    busy_nxt;
   logic                    done_nxt;
`ifdef UART_TX_ARB_HDR_EN
   logic [IW-1:0]           hdr_id, hdr_id_nxt;
`endif

   logic [NUM_REQ-1:0]      gnt_oh;
   logic [IW-1:0]           gnt_idx;
   logic [DATA_WIDTH-1:0]   words [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx)
   );

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_nxt  = state;
      shift_nxt  = shift_reg;
      cnt_nxt    = byte_cnt;
      ptr_nxt    = rr_ptr;
      grant_nxt  = '0;
      data_nxt   = tx_data;
      valid_nxt  = tx_valid;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
`ifdef UART_TX_ARB_HDR_EN
      hdr_id_nxt = hdr_id;
`endif
      unique case (state)
         ST_IDLE: begin
            if (|req) begin
               shift_nxt = words[gnt_idx];
               grant_nxt = gnt_oh;
               ptr_nxt   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               valid_nxt = 1'b0;
`ifdef UART_TX_ARB_HDR_EN
               hdr_id_nxt = gnt_idx;
               state_nxt  = ST_HDR;
`else
               state_nxt  = ST_SEND;
`endif
            end
         end
`ifdef UART_TX_ARB_HDR_EN
         ST_HDR: begin
            if (!tx_valid) begin
               valid_nxt = 1'b1;
               data_nxt  = hdr_byte(3'(hdr_id));
            end else if (tx_ready) begin
               data_nxt  = shift_reg[7:0];
               state_nxt = ST_SEND;
            end
         end
`endif
         ST_SEND: begin
            if (!tx_valid) begin
               valid_nxt = 1'b1;
               data_nxt  = shift_reg[7:0];
            end else if (tx_ready) begin
               shift_nxt = shift_reg >> BYTE_W;
               cnt_nxt   = byte_cnt + 2'd1;
               if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  valid_nxt = 1'b0;
                  state_nxt = ST_IDLE;
               end else begin
                  data_nxt  = shift_reg[15:8];
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         byte_cnt  <= '0;
         rr_ptr    <= '0;
         grant     <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         busy      <= 1'b0;
         word_done <= 1'b0;
`ifdef UART_TX_ARB_HDR_EN
         hdr_id    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         byte_cnt  <= cnt_nxt;
         rr_ptr    <= ptr_nxt;
         grant     <= grant_nxt;
         tx_data   <= data_nxt;
         tx_valid  <= valid_nxt;
         busy      <= busy_nxt;
         word_done <= done_nxt;
`ifdef UART_TX_ARB_HDR_EN
         hdr_id    <= hdr_id_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Directed scoreboard bench for uart_tx_word_arbiter (honours UART_TX_ARB_HDR_EN).
module tb_uart_tx_word_arbiter;

   localparam int NUM_REQ = 4;
`ifdef UART_TX_ARB_HDR_EN
   localparam int HDR_N    = 1;
   localparam int WORD_CYC = 7;
`else
   localparam int HDR_N    = 0;
   localparam int WORD_CYC = 6;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*32-1:0] req_data;
   logic [NUM_REQ-1:0]    grant;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  busy;
   logic                  word_done;

   uart_tx_word_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .grant     (grant),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .word_done (word_done)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          acc_cnt = 0;
   int          words_seen = 0;
   int          words_exp  = 0;
   logic [7:0]  exp_q[$];
   int          grant_q[$];
   int          gcyc_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input int id, input logic [31:0] w);
      logic [2:0] id3;
      id3 = 3'(id);
`ifdef UART_TX_ARB_HDR_EN
      exp_q.push_back({5'b10100, id3});
`endif
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      grant_q.push_back(id);
      words_exp++;
   endtask

   task automatic wait_grant(input int id);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (grant[id] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk($sformatf("grant_wait_%0d", id), 32'(seen), 32'd1);
   endtask

   task automatic wait_acc(input int target);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (acc_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
      chk("acc_wait", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (exp_q.size() == 0 && busy === 1'b0 && word_done === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_wait", 32'(ok), 32'd1);
   endtask

   // Scoreboard monitor: pops expected bytes on handshakes and expected grants on pulses
   always @(negedge clk) begin
      logic [7:0] eb;
      int         eg;
      cyc++;
      if (rst === 1'b0) begin
         if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            acc_cnt++;
            n_tests++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL byte_extra: observed %0h expected none", tx_data);
            end
            if (exp_q.size() != 0) begin
               eb = exp_q.pop_front();
               chk("tx_byte", 32'(tx_data), 32'(eb));
            end
         end
         if (grant !== '0 && !$isunknown(grant)) begin
            gcyc_q.push_back(cyc);
            chk("grant_no_done", 32'(word_done), 32'd0);
            n_tests++;
            assert (grant_q.size() != 0) else begin
               n_fail++;
               $error("FAIL grant_extra: observed %0h expected none", grant);
            end
            if (grant_q.size() != 0) begin
               eg = grant_q.pop_front();
               chk("grant_onehot", 32'(grant), 32'(1) << eg);
            end
         end
         if (word_done === 1'b1) words_seen++;
      end
   end

   initial begin
      int base;
      rst      = 1'b1;
      req      = '0;
      req_data = '0;
      tx_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_grant",     32'(grant),     32'd0);
      chk("rst_tx_valid",  32'(tx_valid),  32'd0);
      chk("rst_tx_data",   32'(tx_data),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_word_done", 32'(word_done), 32'd0);
      tx_ready = 1'b1;

      // 1: single word, ready tied high, plus req->tx_valid latency
      req_data[0*32 +: 32] = 32'hDEADBEEF;
      push_word(0, 32'hDEADBEEF);
      req[0] = 1'b1;
      wait_grant(0);
      req[0] = 1'b0;
      chk("t1_busy_at_grant", 32'(busy), 32'd1);
      chk("t1_valid_at_grant", 32'(tx_valid), 32'd0);
      tick();
      chk("t1_valid_next", 32'(tx_valid), 32'd1);
      wait_idle();
      chk("t1_words", 32'(words_seen), 32'd1);

      // 2: simultaneous req[1], req[2]; back-to-back word period
      gcyc_q.delete();
      req_data[1*32 +: 32] = 32'h11111111;
      req_data[2*32 +: 32] = 32'h22222222;
      push_word(1, 32'h11111111);
      push_word(2, 32'h22222222);
      req[1] = 1'b1;
      req[2] = 1'b1;
      wait_grant(1);
      req[1] = 1'b0;
      wait_grant(2);
      req[2] = 1'b0;
      wait_idle();
      chk("t2_grants", 32'(gcyc_q.size()), 32'd2);
      if (gcyc_q.size() == 2) chk("t2_period", 32'(gcyc_q[1] - gcyc_q[0]), 32'(WORD_CYC));

      // 3: req[3] held, req[0] arrives mid-word: order 3, 0, 3
      req_data[3*32 +: 32] = 32'h33334444;
      req_data[0*32 +: 32] = 32'h0A0B0C0D;
      push_word(3, 32'h33334444);
      push_word(0, 32'h0A0B0C0D);
      push_word(3, 32'h33334444);
      req[3] = 1'b1;
      wait_grant(3);
      tick();
      tick();
      req[0] = 1'b1;
      wait_grant(0);
      req[0] = 1'b0;
      wait_grant(3);
      req[3] = 1'b0;
      wait_idle();

      // 4: back-pressure on byte 2 holds tx_valid and tx_data
      req_data[1*32 +: 32] = 32'hA5A5C3C3;
      push_word(1, 32'hA5A5C3C3);
      base = acc_cnt;
      req[1] = 1'b1;
      wait_grant(1);
      req[1] = 1'b0;
      wait_acc(base + HDR_N + 2);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_valid", 32'(tx_valid), 32'd1);
         chk("t4_hold_data",  32'(tx_data),  32'hA5);
      end
      tx_ready = 1'b1;
      wait_idle();

      // 5: reset mid-word drops it; rr_ptr back to 0 so req[0] beats req[3]
      req_data[2*32 +: 32] = 32'h0BADF00D;
      grant_q.push_back(2);
`ifdef UART_TX_ARB_HDR_EN
      exp_q.push_back(8'hA2);
`endif
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'hF0);
      base = acc_cnt;
      req[2] = 1'b1;
      wait_grant(2);
      req[2] = 1'b0;
      wait_acc(base + HDR_N + 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", 32'(tx_valid), 32'd0);
      chk("t5_busy",  32'(busy),     32'd0);
      chk("t5_data",  32'(tx_data),  32'd0);
      chk("t5_queue", 32'(exp_q.size()), 32'd0);
      req_data[0*32 +: 32] = 32'h01020304;
      req_data[3*32 +: 32] = 32'h3C3C3C3C;
      push_word(0, 32'h01020304);
      push_word(3, 32'h3C3C3C3C);
      req[0] = 1'b1;
      req[3] = 1'b1;
      wait_grant(0);
      req[0] = 1'b0;
      wait_grant(3);
      req[3] = 1'b0;
      wait_idle();

      // 6: word from requester 2 (header A2 first when framing is enabled)
      req_data[2*32 +: 32] = 32'h0000CAFE;
      push_word(2, 32'h0000CAFE);
      req[2] = 1'b1;
      wait_grant(2);
      req[2] = 1'b0;
      wait_idle();

      repeat (3) tick();
      chk("words_total", 32'(words_seen), 32'(words_exp));
      chk("bytes_left",  32'(exp_q.size()), 32'd0);
      chk("grants_left", 32'(grant_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
